key_event_gen: RTL and testbench
================================

KEY_EVENT_GEN -- requirements
Module: key_event_gen

Interface
REQ-001 SHALL have parameter F_CLK, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter N_KEYS, default 6, number of independent keys (1..16).
REQ-003 SHALL have parameter DEBOUNCE_MS, default 20, stable time in ms required to accept a level change.
REQ-004 SHALL have parameter REPEAT_DELAY_MS, default 500, hold time in ms before the first auto-repeat.
REQ-005 SHALL have parameter REPEAT_MS, default 100, auto-repeat period in ms.
REQ-006 SHALL have port i_clk  input  1  single clock for all logic.
REQ-007 SHALL have port i_rst  input  1  reset, asynchronous assert, active-high.
REQ-008 SHALL have port i_key  input  N_KEYS  raw asynchronous keys, active-low (0 = pressed).
REQ-009 SHALL have port o_key_state  output  N_KEYS  debounced level, active-low, same polarity as i_key.
REQ-010 SHALL have port o_press  output  N_KEYS  one-i_clk pulse per accepted press, plus each auto-repeat.
REQ-011 SHALL have port o_release  output  N_KEYS  one-i_clk pulse per accepted release.

Function
REQ-012 SHALL pass each i_key bit through a 2-flop synchroniser before any other logic.
REQ-013 SHALL generate a shared 1 ms tick, one i_clk wide, every F_CLK/1000 cycles, from a free-running counter wrapping at F_CLK/1000-1.
REQ-014 SHALL run one FSM per key with states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-015 IDLE -> PRESS_WAIT when the synchronised key reads 0; the ms counter clears.
REQ-016 PRESS_WAIT: a read of 1 returns to IDLE with no event; on DEBOUNCE_MS consecutive ticks at 0, go to HELD, drive o_key_state bit to 0 and pulse o_press for exactly one cycle.
REQ-017 HELD -> RELEASE_WAIT when the synchronised key reads 1; the ms counter clears.
REQ-018 RELEASE_WAIT: a read of 0 returns to HELD with no event and keeps the repeat counter; on DEBOUNCE_MS consecutive ticks at 1, go to IDLE, drive o_key_state bit to 1 and pulse o_release for one cycle.
REQ-019 Event latency SHALL be 2 sync cycles plus DEBOUNCE_MS ticks, +/-1 tick of phase.
REQ-020 Per-key ms counters SHALL saturate at their terminal value and never wrap.
REQ-021 Simultaneous events on different keys SHALL all be reported in the same cycle, with no priority or serialisation.
REQ-022 o_press and o_release for the same key SHALL never be asserted in the same cycle.

Reset
REQ-023 While i_rst is high: all FSMs in IDLE, o_key_state all 1, o_press and o_release all 0, tick counter 0, synchronisers 1.
REQ-024 Reset asserted mid-debounce or mid-hold SHALL discard the pending event; no pulse is issued on deassertion.
REQ-025 After deassertion, a key held low throughout SHALL be reported as a new press after the full debounce.

Configuration
REQ-026 Macro KEY_AUTOREPEAT_EN defined: in HELD, after REPEAT_DELAY_MS ticks, pulse o_press once, then again every REPEAT_MS ticks until the key leaves HELD.
REQ-027 Macro KEY_AUTOREPEAT_EN undefined: the repeat counter logic is absent, and exactly one o_press is issued per accepted press.

Structure
REQ-028 Package key_event_pkg SHALL hold the FSM state enum, MS_TICK_DIV = F_CLK/1000 for the default F_CLK, and the counter width constant.
REQ-029 The per-key FSM SHALL be sub-module key_debounce_fsm, instantiated N_KEYS times in a generate loop, fed the shared tick.

Verification
REQ-030 Bench SHALL use F_CLK=100000 (100-cycle tick), DEBOUNCE_MS=20, REPEAT_DELAY_MS=500, REPEAT_MS=100.
REQ-031 Key0 low 30 ms -> one o_press[0] pulse about 20 ms after the edge; o_key_state[0]=0; no o_release.
REQ-032 Key0 toggled every 5 ms for 100 ms, then held high -> no o_press, no o_release; o_key_state[0] stays 1.
REQ-033 Key0 and key5 pressed in the same cycle, released 50 ms later -> o_press[0] and o_press[5] pulse in the same cycle, later o_release[0] and o_release[5] pulse in the same cycle.
REQ-034 KEY_AUTOREPEAT_EN defined, key1 held 800 ms -> o_press[1] at about 20, 520, 620, 720 ms after the edge; undefined -> only the 20 ms pulse.
REQ-035 Key2 held, i_rst pulsed at 10 ms of HELD, key kept low -> outputs return to reset values, then a fresh o_press[2] 20 ms after deassertion.

Source files
------------

// File: rtl/key_event_pkg.sv
// Shared types and constants for the key event generator.
package key_event_pkg;

  // Per-key debounce/hold state machine encoding
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_fsm_e;

  // 1 ms tick divider for the default 50 MHz clock
  localparam int MS_TICK_DIV = 50000000 / 1000;

  // Width of the per-key millisecond counters (covers delays up to 65535 ms)
  localparam int MS_CNT_W = 16;

endpackage

// File: rtl/key_debounce_fsm.sv
// Debounce and hold FSM for one key, driven by a shared 1 ms tick.
// Optional auto-repeat while held is enabled by defining KEY_AUTOREPEAT_EN.
module key_debounce_fsm
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_MS       = 100
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_key_sync,
  output logic o_key_state,
  output logic o_press,
  output logic o_release
);

  localparam logic [MS_CNT_W-1:0] DB_TERM = MS_CNT_W'(DEBOUNCE_MS);

  // Counters stop at their terminal value instead of wrapping
  function automatic logic [MS_CNT_W-1:0] sat_inc(input logic [MS_CNT_W-1:0] v,
                                                  input logic [MS_CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + MS_CNT_W'(1);
  endfunction

  key_fsm_e            state_q, state_d;
  logic [MS_CNT_W-1:0] ms_cnt_q, ms_cnt_d;
  logic                key_state_q, key_state_d;
  logic                press_d, release_d;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [MS_CNT_W-1:0] RPT_DELAY_TERM = MS_CNT_W'(REPEAT_DELAY_MS);
  localparam logic [MS_CNT_W-1:0] RPT_TERM       = MS_CNT_W'(REPEAT_MS);

  logic [MS_CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic                rpt_armed_q, rpt_armed_d;
  logic [MS_CNT_W-1:0] rpt_lim;
`endif

  // State, counters and registered event outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      ms_cnt_q    <= '0;
      key_state_q <= 1'b1;
      o_press     <= 1'b0;
      o_release   <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ms_cnt_q    <= ms_cnt_d;
      key_state_q <= key_state_d;
      o_press     <= press_d;
      o_release   <= release_d;
`ifdef KEY_AUTOREPEAT_EN
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
`endif
    end
  end

  // Next-state, counter update and event decode
  always_comb begin
    state_d     = state_q;
    ms_cnt_d    = ms_cnt_q;
    key_state_d = key_state_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    rpt_cnt_d   = rpt_cnt_q;
    rpt_armed_d = rpt_armed_q;
    rpt_lim     = rpt_armed_q ? RPT_TERM : RPT_DELAY_TERM;
`endif
    case (state_q)
      IDLE: begin
        if (!i_key_sync) begin
          state_d  = PRESS_WAIT;
          ms_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (i_key_sync) begin
          state_d = IDLE;
        end else if (i_tick) begin
          ms_cnt_d = sat_inc(ms_cnt_q, DB_TERM);
          if (ms_cnt_d == DB_TERM) begin
            state_d     = HELD;
            key_state_d = 1'b0;
            press_d     = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            rpt_cnt_d   = '0;
            rpt_armed_d = 1'b0;
`endif
          end
        end
      end
      HELD: begin
        if (i_key_sync) begin
          state_d  = RELEASE_WAIT;
          ms_cnt_d = '0;
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (i_tick) begin
          rpt_cnt_d = sat_inc(rpt_cnt_q, rpt_lim);
          if (rpt_cnt_d == rpt_lim) begin
            press_d     = 1'b1;
            rpt_cnt_d   = '0;
            rpt_armed_d = 1'b1;
          end
        end
`endif
      end
      RELEASE_WAIT: begin
        // A bounce back to 0 resumes the hold; the repeat schedule is kept
        if (!i_key_sync) begin
          state_d = HELD;
        end else if (i_tick) begin
          ms_cnt_d = sat_inc(ms_cnt_q, DB_TERM);
          if (ms_cnt_d == DB_TERM) begin
            state_d     = IDLE;
            key_state_d = 1'b1;
            release_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_key_state = key_state_q;

endmodule

// File: rtl/key_event_gen.sv
// Multi-key debouncer with press/release event pulses.
// Build macro KEY_AUTOREPEAT_EN adds auto-repeat press pulses while a key is held.
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int F_CLK           = 50000000,
  parameter int N_KEYS          = 6,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_MS       = 100
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_KEYS-1:0] i_key,
  output logic [N_KEYS-1:0] o_key_state,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release
);

  localparam int TICK_DIV = F_CLK / 1000;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [N_KEYS-1:0] key_sync_p0, key_sync_p1;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  // Two-flop synchroniser; idles at 1 (released) so reset never looks like a press
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      key_sync_p0 <= '1;
      key_sync_p1 <= '1;
    end else begin
      key_sync_p0 <= i_key;
      key_sync_p1 <= key_sync_p0;
    end
  end

  // Free-running millisecond divider producing a one-cycle tick
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick     <= (tick_cnt == TICK_LAST);
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce_fsm #(
      .DEBOUNCE_MS     (DEBOUNCE_MS),
      .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
      .REPEAT_MS       (REPEAT_MS)
    ) u_fsm (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_tick      (tick),
      .i_key_sync  (key_sync_p1[k]),
      .o_key_state (o_key_state[k]),
      .o_press     (o_press[k]),
      .o_release   (o_release[k])
    );
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen at a 100-cycle millisecond tick.
module tb_key_event_gen;

  localparam int NK     = 6;
  localparam int CYC_MS = 100;

`ifdef KEY_AUTOREPEAT_EN
  localparam int K1_EXP_PRESSES = 4;
`else
  localparam int K1_EXP_PRESSES = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key;
  logic [NK-1:0] key_state, press, rel;

  always #5 clk = ~clk;

  key_event_gen #(
    .F_CLK           (100000),
    .N_KEYS          (NK),
    .DEBOUNCE_MS     (20),
    .REPEAT_DELAY_MS (500),
    .REPEAT_MS       (100)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_key       (key),
    .o_key_state (key_state),
    .o_press     (press),
    .o_release   (rel)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int press_cnt [NK] = '{default: 0};
  int rel_cnt   [NK] = '{default: 0};
  int last_press[NK] = '{default: 0};
  int last_rel  [NK] = '{default: 0};
  int k0_low_cyc = 0;
  int both_cnt   = 0;
  int k1_press_cyc[$];
  int t1;

  // Event monitor sampled away from the active edge
  always @(negedge clk) begin
    for (int k = 0; k < NK; k++) begin
      if (press[k]) begin
        press_cnt[k]  = press_cnt[k] + 1;
        last_press[k] = cyc;
      end
      if (rel[k]) begin
        rel_cnt[k]  = rel_cnt[k] + 1;
        last_rel[k] = cyc;
      end
      if (press[k] && rel[k]) both_cnt = both_cnt + 1;
    end
    if (!key_state[0]) k0_low_cyc = k0_low_cyc + 1;
    if (press[1]) k1_press_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Collapse a value inside [lo,hi] to its nominal value; outside, keep it for the report
  function automatic int win(input int v, input int lo, input int hi, input int nom);
    return (v >= lo && v <= hi) ? nom : v;
  endfunction

  task automatic wait_ms(input int ms);
    repeat (ms * CYC_MS) @(negedge clk);
  endtask

  int p0, r0, p5, r5, p2, r2, lowsnap, t0, td;

  initial begin
    rst = 1'b1;
    key = '1;
    repeat (5) @(negedge clk);
    chk("rst_key_state", int'(key_state), 'h3F);
    chk("rst_press", int'(press), 0);
    chk("rst_release", int'(rel), 0);
    rst = 1'b0;
    @(negedge clk);

    fork
      begin
        // key1: long hold for auto-repeat, runs alongside the key0/key5 tests
        t1 = cyc;
        key[1] = 1'b0;
        wait_ms(730);
        key[1] = 1'b1;
        wait_ms(22);
      end
      begin
        // single clean press of key0
        p0 = press_cnt[0]; r0 = rel_cnt[0];
        t0 = cyc;
        key[0] = 1'b0;
        wait_ms(30);
        chk("k0_press_cnt", press_cnt[0] - p0, 1);
        chk("k0_press_lat", win(last_press[0] - t0, 1900, 2110, 2000), 2000);
        chk("k0_state_low", int'(key_state[0]), 0);
        chk("k0_no_release", rel_cnt[0] - r0, 0);
        key[0] = 1'b1;
        wait_ms(25);
        chk("k0_release_cnt", rel_cnt[0] - r0, 1);
        chk("k0_state_high", int'(key_state[0]), 1);

        // key0 bouncing every 5 ms never settles long enough
        p0 = press_cnt[0]; r0 = rel_cnt[0]; lowsnap = k0_low_cyc;
        for (int i = 0; i < 20; i++) begin
          key[0] = ~key[0];
          wait_ms(5);
        end
        key[0] = 1'b1;
        wait_ms(25);
        chk("bounce_no_press", press_cnt[0] - p0, 0);
        chk("bounce_no_release", rel_cnt[0] - r0, 0);
        chk("bounce_state_low_cycles", k0_low_cyc - lowsnap, 0);

        // key0 and key5 together
        p0 = press_cnt[0]; r0 = rel_cnt[0]; p5 = press_cnt[5]; r5 = rel_cnt[5];
        key = key & 6'b011110;
        wait_ms(50);
        chk("k05_press0_cnt", press_cnt[0] - p0, 1);
        chk("k05_press5_cnt", press_cnt[5] - p5, 1);
        chk("k05_press_same_cyc", last_press[5], last_press[0]);
        chk("k05_state_low", int'(key_state & 6'b100001), 0);
        key = key | 6'b100001;
        wait_ms(25);
        chk("k05_rel0_cnt", rel_cnt[0] - r0, 1);
        chk("k05_rel5_cnt", rel_cnt[5] - r5, 1);
        chk("k05_rel_same_cyc", last_rel[5], last_rel[0]);
        chk("k05_state_high", int'(key_state & 6'b100001), 'h21);
      end
    join

    // key1 auto-repeat schedule
    chk("k1_press_cnt", k1_press_cyc.size(), K1_EXP_PRESSES);
    if (k1_press_cyc.size() >= 1)
      chk("k1_first_lat", win(k1_press_cyc[0] - t1, 1900, 2110, 2000), 2000);
    if (k1_press_cyc.size() >= 4) begin
      chk("k1_rep1_gap", k1_press_cyc[1] - k1_press_cyc[0], 50000);
      chk("k1_rep2_gap", k1_press_cyc[2] - k1_press_cyc[1], 10000);
      chk("k1_rep3_gap", k1_press_cyc[3] - k1_press_cyc[2], 10000);
    end
    chk("k1_release_cnt", rel_cnt[1], 1);

    // key2 held through a reset pulse
    p2 = press_cnt[2]; r2 = rel_cnt[2];
    key[2] = 1'b0;
    wait_ms(30);
    chk("k2_press_cnt", press_cnt[2] - p2, 1);
    chk("k2_state_low", int'(key_state[2]), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("k2_rst_key_state", int'(key_state), 'h3F);
    chk("k2_rst_press", int'(press), 0);
    chk("k2_rst_release", int'(rel), 0);
    rst = 1'b0;
    td = cyc;
    wait_ms(25);
    chk("k2_repress_cnt", press_cnt[2] - p2, 2);
    chk("k2_no_release", rel_cnt[2] - r2, 0);
    chk("k2_repress_lat", win(last_press[2] - td, 1990, 2110, 2000), 2000);
    chk("k2_state_low_again", int'(key_state[2]), 0);
    key[2] = 1'b1;

    chk("press_release_overlap", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
